reg_scoreboard: RTL and testbench

- Tracks outstanding register-file writes for the 32-entry, 32-bit register file read by the decode stage.
- Decode presents each instruction's source and destination selects. The block stalls decode on any read-after-write hazard, or when a destination's in-flight counter is saturated.
- Writeback retires entries.
- Sits between decode and the pipeline control; it produces the decode stall and issue signals.

---
 rtl/sched_pkg.sv | 12 +
 rtl/sb_counter.sv | 44 ++++
 rtl/reg_scoreboard.sv | 73 +++++++
 tb/tb_reg_scoreboard.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared scheduling types for the decode scoreboard.
// Register select width and the in-flight counter limit.
package sched_pkg;

    localparam int NREG      = 32;
    localparam int REG_SEL_W = 5;
    localparam int CNT_BITS  = 2;
    localparam int CNT_MAX   = (1 << CNT_BITS) - 1;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

endpackage

// File: rtl/sb_counter.sv
// One register's in-flight write counter.
// Counts issued writes up and retired writes down, with a synchronous clear.
module sb_counter #(
    parameter int CNT_W    = 2,
    parameter bit TIE_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wb,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic             dec;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        dec = wb & (count != '0);
        nxt = count;
        if (flush) begin
            nxt = '0;
        end else if (inc && !dec && count != MAX) begin
            nxt = count + 1'b1;
        end else if (dec && !inc) begin
            nxt = count - 1'b1;
        end
        // A hard-wired register never holds writes in flight
        if (TIE_ZERO) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard for decode.
// Stalls on RAW hazards and on saturated per-register write counts.
module reg_scoreboard
    import sched_pkg::*;
#(
    parameter int NREG     = sched_pkg::NREG,
    parameter int CNT_W    = sched_pkg::CNT_BITS,
    parameter bit ZERO_REG = 1'b1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  reg_sel_t          dec_src1,
    input  logic              dec_src1_used,
    input  reg_sel_t          dec_src2,
    input  logic              dec_src2_used,
    input  reg_sel_t          dec_dst,
    input  logic              dec_dst_wr,
    input  logic              wb_valid,
    input  reg_sel_t          wb_sel,
    input  logic              flush,
    output logic              dec_stall,
    output logic              issue,
    output logic [NREG-1:0]   pending,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];

    logic raw1;
    logic raw2;
    logic waw_full;

    always_comb begin
        raw1     = dec_src1_used & (cnt[dec_src1] != '0);
        raw2     = dec_src2_used & (cnt[dec_src2] != '0);
        waw_full = dec_dst_wr & (cnt[dec_dst] == MAX);
        if (ZERO_REG) begin
            if (dec_src1 == '0) raw1 = 1'b0;
            if (dec_src2 == '0) raw2 = 1'b0;
            if (dec_dst == '0)  waw_full = 1'b0;
        end
        dec_stall = dec_valid & (raw1 | raw2 | waw_full);
        issue     = dec_valid & ~dec_stall;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_cnt
        sb_counter #(
            .CNT_W    (CNT_W),
            .TIE_ZERO (ZERO_REG && i == 0)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (issue & dec_dst_wr & (dec_dst == reg_sel_t'(i))),
            .wb    (wb_valid & (wb_sel == reg_sel_t'(i))),
            .flush (flush),
            .count (cnt[i])
        );
        assign pending[i] = (cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (dec_stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for the register scoreboard.
// Table rows cover the single-cycle rules; hand sequences cover reset and saturation.
module tb_reg_scoreboard;
    import sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    reg_sel_t    dec_src1;
    logic        dec_src1_used;
    reg_sel_t    dec_src2;
    logic        dec_src2_used;
    reg_sel_t    dec_dst;
    logic        dec_dst_wr;
    logic        wb_valid;
    reg_sel_t    wb_sel;
    logic        flush;
    logic        dec_stall;
    logic        issue;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    int n_pass = 0;
    int n_total = 0;

    reg_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (dec_valid),
        .dec_src1      (dec_src1),
        .dec_src1_used (dec_src1_used),
        .dec_src2      (dec_src2),
        .dec_src2_used (dec_src2_used),
        .dec_dst       (dec_dst),
        .dec_dst_wr    (dec_dst_wr),
        .wb_valid      (wb_valid),
        .wb_sel        (wb_sel),
        .flush         (flush),
        .dec_stall     (dec_stall),
        .issue         (issue),
        .pending       (pending),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  s1;
        logic        s1u;
        logic [4:0]  s2;
        logic        s2u;
        logic [4:0]  d;
        logic        dw;
        logic        wbv;
        logic [4:0]  wbs;
        logic        fl;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    function automatic vec_t v(
        input logic valid, input int s1, input logic s1u,
        input int s2, input logic s2u, input int d, input logic dw,
        input logic wbv, input int wbs, input logic fl,
        input logic es, input logic ei, input logic [31:0] ep);
        vec_t r;
        r.valid = valid; r.s1 = 5'(s1); r.s1u = s1u;
        r.s2 = 5'(s2); r.s2u = s2u; r.d = 5'(d); r.dw = dw;
        r.wbv = wbv; r.wbs = 5'(wbs); r.fl = fl;
        r.e_stall = es; r.e_issue = ei; r.e_pend = ep;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        dec_valid = 0; dec_src1 = 0; dec_src1_used = 0;
        dec_src2 = 0; dec_src2_used = 0; dec_dst = 0; dec_dst_wr = 0;
        wb_valid = 0; wb_sel = 0; flush = 0;
    endtask

    initial begin
        // columns: valid s1 s1u s2 s2u dst dw wbv wbs flush | stall issue pending-after-edge
        vt.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0, 0,1, b(7)));
        vt.push_back(v(1, 7,1, 0,0, 8,1, 0,0, 0, 1,0, b(7)));
        vt.push_back(v(1, 7,1, 0,0, 8,1, 1,7, 0, 1,0, 0));
        vt.push_back(v(1, 7,1, 0,0, 8,1, 0,0, 0, 0,1, b(8)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,8, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 0,1, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 0,1, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 0,1, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 1,0, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 1,3, 0, 1,0, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 0,1, b(3)));
        vt.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 1,0, b(3)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0, 0,0, b(3)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0, 0,0, b(3)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 4,1, 0,0, 0, 0,1, b(4)));
        vt.push_back(v(1, 0,0, 0,0, 4,1, 1,4, 0, 0,1, b(4)));
        vt.push_back(v(1, 4,1, 0,0, 0,0, 0,0, 0, 1,0, b(4)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,4, 0, 0,0, 0));
        vt.push_back(v(1, 5,1, 0,0, 5,1, 0,0, 0, 0,1, b(5)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,5, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 0,1, 0,0, 0, 0,1, 0));
        vt.push_back(v(1, 0,1, 0,1, 0,1, 0,0, 0, 0,1, 0));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,0, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 9,1, 0,0, 0, 0,1, b(9)));
        vt.push_back(v(1, 1,0, 9,1, 0,0, 0,0, 0, 1,0, b(9)));
        vt.push_back(v(1, 1,0, 9,0, 0,0, 0,0, 0, 0,1, b(9)));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,9, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 0,1, b(2)));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 0,1, b(2)));
        vt.push_back(v(1, 0,0, 0,0, 9,1, 0,0, 0, 0,1, b(2) | b(9)));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 1, 0,1, 0));
        vt.push_back(v(0, 0,0, 0,0, 0,0, 1,2, 0, 0,0, 0));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 0,1, b(2)));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 0,1, b(2)));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 0,1, b(2)));
        vt.push_back(v(1, 0,0, 0,0, 2,1, 0,0, 0, 1,0, b(2)));

        idle();
        rst_n = 0;
        #1;
        check("reset_pending", pending, 0);
        check("reset_stall_cycles", 32'(stall_cycles), 0);
        check("reset_dec_stall", 32'(dec_stall), 0);
        check("reset_issue", 32'(issue), 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) begin
            @(negedge clk);
            dec_valid = vt[i].valid;
            dec_src1 = vt[i].s1; dec_src1_used = vt[i].s1u;
            dec_src2 = vt[i].s2; dec_src2_used = vt[i].s2u;
            dec_dst = vt[i].d; dec_dst_wr = vt[i].dw;
            wb_valid = vt[i].wbv; wb_sel = vt[i].wbs; flush = vt[i].fl;
            #1;
            check($sformatf("v%0d_stall", i), 32'(dec_stall), 32'(vt[i].e_stall));
            check($sformatf("v%0d_issue", i), 32'(issue), 32'(vt[i].e_issue));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pending", i), pending, vt[i].e_pend);
        end
        // rows 2,3,9,10,12,18,26 and the last row stall; flush does not clear
        check("stall_cycles_after_table", 32'(stall_cycles), 8);

        @(negedge clk);
        idle();
        rst_n = 0;
        #1;
        rst_n = 1;
        check("reset_clears_r2", pending, 0);

        // reset in the middle of traffic
        @(negedge clk);
        idle();
        dec_valid = 1; dec_dst = 7; dec_dst_wr = 1;
        @(posedge clk);
        #1;
        check("mid_issue_r7", pending, b(7));
        @(negedge clk);
        idle();
        dec_valid = 1; dec_src1 = 7; dec_src1_used = 1;
        #1;
        check("mid_raw_r7", 32'(dec_stall), 1);
        #2;
        rst_n = 0;
        #1;
        check("mid_reset_pending", pending, 0);
        check("mid_reset_stall_cycles", 32'(stall_cycles), 0);
        check("mid_reset_dec_stall", 32'(dec_stall), 0);
        check("mid_reset_issue", 32'(issue), 1);
        @(negedge clk);
        rst_n = 1;
        idle();
        wb_valid = 1; wb_sel = 7;
        @(posedge clk);
        #1;
        check("post_reset_wb_ignored", pending, 0);
        @(negedge clk);
        idle();
        dec_valid = 1; dec_src1 = 7; dec_src1_used = 1;
        #1;
        check("post_reset_no_stall", 32'(dec_stall), 0);

        // long forced stall to reach counter saturation
        @(negedge clk);
        idle();
        dec_valid = 1; dec_dst = 11; dec_dst_wr = 1;
        @(negedge clk);
        idle();
        dec_valid = 1; dec_src1 = 11; dec_src1_used = 1;
        repeat (65540) @(posedge clk);
        #1;
        check("stall_cycles_saturated", 32'(stall_cycles), 32'h0000_FFFF);
        check("sat_still_stalled", 32'(dec_stall), 1);
        check("sat_pending_r11", pending, b(11));
        @(negedge clk);
        idle();
        flush = 1;
        @(posedge clk);
        #1;
        check("sat_flush_pending", pending, 0);
        check("sat_flush_keeps_stat", 32'(stall_cycles), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
